// File: rtl/iterative_multiplier.sv
// iterative_multiplier
//
// Multi-cycle multiplier / multiply-accumulate unit with a start/busy/done
// handshake. The unit retires BPC multiplier bits per cycle (LSB first) into a
// 2*WIDTH accumulator. It then spends one finishing cycle that applies the
// product sign and adds the accumulate operand.
//
// Parameters:
//   WIDTH  operand width (must be divisible by BPC)
//   BPC    multiplier bits retired per RUN cycle (1, 2 or 4)
//
// Ports:
//   clk      clock, all state changes on the rising edge
//   reset    synchronous, active-high reset
//   start    operation request, accepted only when busy=0
//   op_type  operation: 0 MUL, 1 MLA, 2 UMULL, 3 UMLAL, 4 SMULL, 5 SMLAL,
//            6/7 behave as MUL. The name "type" is a reserved SystemVerilog
//            keyword, so the port is called op_type.
//   a, b     multiplicand, multiplier
//   c, d     accumulate low / high words
//   busy     operation in progress (RUN or FIN)
//   done     one-cycle pulse, result valid
//   result   2*WIDTH product or accumulated value
//   n, z     sign / zero of result at operation width
//
// Optional feature:
//   MUL_EARLY_TERM_EN  when defined, RUN ends as soon as the remaining
//                      unretired multiplier magnitude bits are all zero.

module iterative_multiplier #(
  parameter int WIDTH = 32,
  parameter int BPC   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op_type,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  input  logic [WIDTH-1:0]   d,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               n,
  output logic               z
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN,
    DONE
  } state_t;

  state_t state;

  // Operation context captured at start
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] addend;
  logic               neg;
  logic               is_long;
  logic [CW-1:0]      cnt;

  // Decode of the incoming request
  logic               start_signed;
  logic               start_long;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] start_addend;

  // Datapath helpers
  logic [2*WIDTH-1:0] step_sum;
  logic               last_run;
  logic [2*WIDTH-1:0] signed_prod;
  logic [2*WIDTH-1:0] fin_sum;
  logic [2*WIDTH-1:0] fin_result;
  logic               fin_n;
  logic               fin_z;

  // Decode the requested operation. The signed types turn the operands into
  // magnitudes so the RUN loop is always an unsigned shift-and-add. The sign
  // is reapplied in FIN.
  always_comb begin
    start_signed = 1'b0;
    start_long   = 1'b0;
    start_addend = '0;
    case (op_type)
      3'd1: start_addend = {{WIDTH{1'b0}}, c};
      3'd2: start_long   = 1'b1;
      3'd3: begin
        start_long   = 1'b1;
        start_addend = {d, c};
      end
      3'd4: begin
        start_long   = 1'b1;
        start_signed = 1'b1;
      end
      3'd5: begin
        start_long   = 1'b1;
        start_signed = 1'b1;
        start_addend = {d, c};
      end
      default: begin
        start_long   = 1'b0;
        start_signed = 1'b0;
        start_addend = '0;
      end
    endcase
    mag_a = (start_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    mag_b = (start_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
  end

  // One RUN step: add the shifted multiplicand for every set multiplier bit in
  // the current BPC-bit group. The multiplicand register is pre-shifted each
  // cycle, so bit i of the group only needs a further shift by i.
  always_comb begin
    step_sum = acc;
    for (int i = 0; i < BPC; i++) begin
      if (mplier[i]) begin
        step_sum = step_sum + (mcand << i);
      end
    end
  end

  // Decide whether this RUN cycle is the last one.
  always_comb begin
`ifdef MUL_EARLY_TERM_EN
    last_run = (cnt == CW'(N - 1)) || ((mplier >> BPC) == '0);
`else
    last_run = (cnt == CW'(N - 1));
`endif
  end

  // Finishing arithmetic: apply the product sign, add the accumulate operand
  // (mod 2^(2*WIDTH)), then mask to operation width for the 32-bit types.
  always_comb begin
    signed_prod = neg ? (~acc + 1'b1) : acc;
    fin_sum     = signed_prod + addend;
    if (is_long) begin
      fin_result = fin_sum;
      fin_n      = fin_sum[2*WIDTH-1];
    end else begin
      fin_result = {{WIDTH{1'b0}}, fin_sum[WIDTH-1:0]};
      fin_n      = fin_sum[WIDTH-1];
    end
    fin_z = (fin_result == '0);
  end

  // Control FSM with registered handshake outputs. busy is high while the
  // state is RUN or FIN. done is high only in DONE. A start seen in DONE
  // is accepted exactly as in IDLE, which gives back-to-back operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      n       <= 1'b0;
      z       <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      addend  <= '0;
      neg     <= 1'b0;
      is_long <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand   <= {{WIDTH{1'b0}}, mag_a};
            mplier  <= mag_b;
            acc     <= '0;
            addend  <= start_addend;
            neg     <= start_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            is_long <= start_long;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          acc    <= step_sum;
          mcand  <= mcand << BPC;
          mplier <= mplier >> BPC;
          cnt    <= cnt + CW'(1);
          if (last_run) begin
            state <= FIN;
          end
        end
        FIN: begin
          result <= fin_result;
          n      <= fin_n;
          z      <= fin_z;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
